proc_core: RTL and testbench
============================

# proc_core

Single-bus 32-bit processor datapath (the DUT `proc`), controlled step by step by externally driven control signals. It contains the register file, PC, IR, MAR, MDR, Y, the 64-bit Z, HI/LO, the ALU, the select-and-encode logic, the CON flip-flop and a 512-word RAM, all connected through one shared 32-bit bus. It sits under the control unit or testbench, which sequences T-states by asserting the control inputs.

## Interface
- No parameters. Fixed sizes: 32-bit word, 16 general registers, 512×32 RAM.
- `clk  in  1`: rising-edge clock.
- `reset  in  1`: synchronous, active-high reset.
- Bus drivers, each `in 1`: `PCout`, `MDRout`, `Zhighout`, `Zlowout`, `HIout`, `LOout`, `Cout`, `InPortout`, `Rout`, `BAout`.
- Load enables, each `in 1`: `PCin`, `IRin`, `MARin`, `MDRin`, `Yin`, `Zin`, `HIin`, `LOin`, `Rin`, `CONin`, `OutPortin`.
- Register select, each `in 1`: `Gra`, `Grb`, `Grc`.
- Memory control, each `in 1`: `Read`, `Write`.
- `IncPC  in  1`: ALU computes bus+1, overriding `alu_op`.
- `alu_op  in  4`: ADD=0, SUB=1, AND=2, OR=3, SHR=4, SHRA=5, SHL=6, ROR=7, ROL=8, MUL=9, DIV=10, NEG=11, NOT=12. Codes 13–15 give 0.
- `in_port  in  32`: external input word.
- `out_port  out  32`: registered output port.
- `bus  out  32`: current bus value.
- `con_ff  out  1`: branch condition flip-flop.

## Operation
- IR fields:
  - opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
  - C2 = IR[20:19].
  - C = IR[18:0], sign-extended to 32 bits.
- Select/encode: the selected index is the OR of (`Gra`&Ra), (`Grb`&Rb) and (`Grc`&Rc).
  - `Rin` writes R[index] from the bus.
  - `Rout` drives R[index].
  - `BAout` drives R[index], or 0 when index = 0.
- Bus is a combinational mux. Exactly one driver should be active. If several are active, fixed priority applies: PCout > MDRout > Zhighout > Zlowout > HIout > LOout > Cout > InPortout > Rout/BAout. With no driver active, the bus is 0.
- Register loads, on the clock edge when the enable is high:
  - PC, IR, MAR, Y, HI, LO and out_port load from the bus.
  - R[index] loads from the bus when `Rin` is high.
- MDR:
  - `MDRin` & `Read` loads mem[MAR[8:0]].
  - `MDRin` & !`Read` loads the bus.
- `Write` stores MDR into mem[MAR[8:0]].
- ALU: A = Y, B = bus. The result is 64-bit and is latched into Z when `Zin` is high.
  - ADD/SUB/AND/OR/NEG/NOT produce a 32-bit result, zero-extended into Z.
  - Shifts and rotates use B[4:0] as the amount. SHRA is arithmetic.
  - MUL is signed 32×32 → 64: high word to Z[63:32], low word to Z[31:0].
  - DIV is signed: quotient to Z[31:0], remainder to Z[63:32]. Dividing by 0 gives 0 in both halves.
  - `IncPC`: Z = {32'b0, B+1}.
- CON FF, loaded when `CONin` is high, evaluated on the bus value:
  - C2 = 00: bus == 0.
  - C2 = 01: bus != 0.
  - C2 = 10: bus[31] == 0.
  - C2 = 11: bus[31] == 1.
- Reset clears PC, IR, MAR, MDR, Y, Z, HI, LO, R0–R15, out_port and con_ff to 0. RAM is not cleared and is preloadable by hierarchical access.

## Timing
- One control step = one clock. All loads happen at the rising edge that samples the enables.
- The bus and ALU are combinational within the step, so a value driven in a step is captured at that step's edge.
- Memory read is asynchronous: the MDR holds mem[MAR] one edge after `Read`/`MDRin`. MAR must be loaded in an earlier step.
- A write to a register used as a bus source in the same step captures the old value.
- Reset overrides all enables in the same cycle.

## Test plan
- Fetch with PC=7 and mem[7]=0x10800023:
  - T0: `PCout`, `MARin`, `IncPC`, `Zin` → MAR=7, Z=8.
  - T1: `Zlowout`, `PCin`, `Read`, `MDRin` → PC=8, MDR=0x10800023.
  - T2: `MDRout`, `IRin` → IR=0x10800023.
- Same IR; `Cout`, `Gra`, `Rin` → R1=35. Then `Gra`, `Rout`, `PCin` → PC=35.
- R1=35, R2=7:
  - `Rout`(R1) with `Yin`.
  - `Rout`(R2), `alu_op`=ADD, `Zin`.
  - `Zlowout` into R3 → R3=42.
  - Repeat with SUB → 28, and with MUL → LO=245, HI=0.
- Branch condition: with C2=00 and bus=0, `CONin` → con_ff=1. With C2=11 and bus=0x80000000 → 1. With C2=01 and bus=0 → 0.
- Memory write: MAR=20, MDR=0xDEADBEEF, `Write` → mem[20]=0xDEADBEEF. A later `Read`/`MDRin` returns the same value.
- Assert `reset` mid-sequence → PC, IR, Z, R1 and con_ff read 0 after the edge, and RAM is unchanged.

Source files
------------

// File: rtl/proc_core.sv
// Single-bus 32-bit datapath: register file, PC/IR/MAR/MDR, Y/Z/HI/LO, ALU, CON flip-flop
// and a 512-word RAM, all sequenced one control step per clock by external control lines.
module proc_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCout,
    input  logic        MDRout,
    input  logic        Zhighout,
    input  logic        Zlowout,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        Cout,
    input  logic        InPortout,
    input  logic        Rout,
    input  logic        BAout,
    input  logic        PCin,
    input  logic        IRin,
    input  logic        MARin,
    input  logic        MDRin,
    input  logic        Yin,
    input  logic        Zin,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        Rin,
    input  logic        CONin,
    input  logic        OutPortin,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        Read,
    input  logic        Write,
    input  logic        IncPC,
    input  logic [3:0]  alu_op,
    input  logic [31:0] in_port,
    output logic [31:0] out_port,
    output logic [31:0] bus,
    output logic        con_ff
);

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpAnd  = 4'd2;
    localparam logic [3:0] OpOr   = 4'd3;
    localparam logic [3:0] OpShr  = 4'd4;
    localparam logic [3:0] OpShra = 4'd5;
    localparam logic [3:0] OpShl  = 4'd6;
    localparam logic [3:0] OpRor  = 4'd7;
    localparam logic [3:0] OpRol  = 4'd8;
    localparam logic [3:0] OpMul  = 4'd9;
    localparam logic [3:0] OpDiv  = 4'd10;
    localparam logic [3:0] OpNeg  = 4'd11;
    localparam logic [3:0] OpNot  = 4'd12;

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [8:0]  mar_q, mar_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] y_q, y_d;
    logic [63:0] z_q, z_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] out_port_q, out_port_d;
    logic        con_q, con_d;
    logic [31:0] regs_q [16];
    logic [31:0] regs_d [16];
    logic [31:0] ram [512];

    // IR field decode
    logic [3:0]  ra, rb, rc, sel_idx;
    logic [1:0]  c2;
    logic [31:0] c_sext;
    logic        unused_opcode;

    assign ra            = ir_q[26:23];
    assign rb            = ir_q[22:19];
    assign rc            = ir_q[18:15];
    assign c2            = ir_q[20:19];
    assign c_sext        = {{13{ir_q[18]}}, ir_q[18:0]};
    assign unused_opcode = ^ir_q[31:27];
    assign sel_idx       = ({4{Gra}} & ra) | ({4{Grb}} & rb) | ({4{Grc}} & rc);

    // Shared bus: fixed priority when more than one driver is enabled
    always_comb begin
        bus = '0;
        if (PCout)          bus = pc_q;
        else if (MDRout)    bus = mdr_q;
        else if (Zhighout)  bus = z_q[63:32];
        else if (Zlowout)   bus = z_q[31:0];
        else if (HIout)     bus = hi_q;
        else if (LOout)     bus = lo_q;
        else if (Cout)      bus = c_sext;
        else if (InPortout) bus = in_port;
        else if (Rout)      bus = regs_q[sel_idx];
        else if (BAout)     bus = (sel_idx == 4'd0) ? 32'd0 : regs_q[sel_idx];
    end

    // ALU: A operand is Y, B operand is the bus
    logic [31:0]        alu_a, alu_b;
    logic [4:0]         shamt;
    logic [63:0]        alu_res;
    logic signed [63:0] prod;
    logic signed [31:0] quo, rem;

    assign alu_a = y_q;
    assign alu_b = bus;
    assign shamt = bus[4:0];

    always_comb begin
        alu_res = '0;
        quo     = '0;
        rem     = '0;
        prod    = $signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b});
        if (IncPC) begin
            alu_res = {32'd0, alu_b + 32'd1};
        end else begin
            case (alu_op)
                OpAdd:  alu_res = {32'd0, alu_a + alu_b};
                OpSub:  alu_res = {32'd0, alu_a - alu_b};
                OpAnd:  alu_res = {32'd0, alu_a & alu_b};
                OpOr:   alu_res = {32'd0, alu_a | alu_b};
                OpShr:  alu_res = {32'd0, alu_a >> shamt};
                OpShra: alu_res = {32'd0, $signed(alu_a) >>> shamt};
                OpShl:  alu_res = {32'd0, alu_a << shamt};
                OpRor:  alu_res = {32'd0, (alu_a >> shamt) | (alu_a << (6'd32 - {1'b0, shamt}))};
                OpRol:  alu_res = {32'd0, (alu_a << shamt) | (alu_a >> (6'd32 - {1'b0, shamt}))};
                OpMul:  alu_res = prod;
                OpDiv: begin
                    // MIN / -1 overflows; handled explicitly so the divider never sees it
                    if (alu_b == 32'd0) begin
                        alu_res = '0;
                    end else if (alu_a == 32'h8000_0000 && alu_b == 32'hffff_ffff) begin
                        alu_res = {32'd0, 32'h8000_0000};
                    end else begin
                        quo     = $signed(alu_a) / $signed(alu_b);
                        rem     = $signed(alu_a) % $signed(alu_b);
                        alu_res = {rem, quo};
                    end
                end
                OpNeg:  alu_res = {32'd0, 32'd0 - alu_b};
                OpNot:  alu_res = {32'd0, ~alu_b};
                default: alu_res = '0;
            endcase
        end
    end

    logic con_eval;

    always_comb begin
        case (c2)
            2'b00:   con_eval = (bus == 32'd0);
            2'b01:   con_eval = (bus != 32'd0);
            2'b10:   con_eval = ~bus[31];
            default: con_eval = bus[31];
        endcase
    end

    always_comb begin
        pc_d       = PCin ? bus : pc_q;
        ir_d       = IRin ? bus : ir_q;
        mar_d      = MARin ? bus[8:0] : mar_q;
        y_d        = Yin ? bus : y_q;
        z_d        = Zin ? alu_res : z_q;
        hi_d       = HIin ? bus : hi_q;
        lo_d       = LOin ? bus : lo_q;
        out_port_d = OutPortin ? bus : out_port_q;
        con_d      = CONin ? con_eval : con_q;
        mdr_d      = mdr_q;
        if (MDRin) mdr_d = Read ? ram[mar_q] : bus;
        regs_d = regs_q;
        if (Rin) regs_d[sel_idx] = bus;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= '0;
            ir_q       <= '0;
            mar_q      <= '0;
            mdr_q      <= '0;
            y_q        <= '0;
            z_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            out_port_q <= '0;
            con_q      <= 1'b0;
            regs_q     <= '{default: '0};
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            mar_q      <= mar_d;
            mdr_q      <= mdr_d;
            y_q        <= y_d;
            z_q        <= z_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            out_port_q <= out_port_d;
            con_q      <= con_d;
            regs_q     <= regs_d;
        end
    end

    // RAM keeps its contents across reset; only writes are suppressed while reset is high
    always_ff @(posedge clk) begin
        if (Write && !reset) ram[mar_q] <= mdr_q;
    end

    assign out_port = out_port_q;
    assign con_ff   = con_q;

endmodule

// File: tb/tb_proc_core.sv
// Self-checking bench for proc_core: ALU vector table, randomized ALU runs against an
// arithmetic reference model, and hand-written fetch/register/memory/branch/reset sequences.
module tb_proc_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout, InPortout, Rout, BAout;
    logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Rin, CONin, OutPortin;
    logic        Gra, Grb, Grc, Read, Write, IncPC;
    logic [3:0]  alu_op;
    logic [31:0] in_port, out_port, bus;
    logic        con_ff;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    proc_core dut (
        .clk(clk), .reset(reset),
        .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout), .InPortout(InPortout),
        .Rout(Rout), .BAout(BAout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
        .HIin(HIin), .LOin(LOin), .Rin(Rin), .CONin(CONin), .OutPortin(OutPortin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Read(Read), .Write(Write), .IncPC(IncPC),
        .alu_op(alu_op), .in_port(in_port), .out_port(out_port), .bus(bus), .con_ff(con_ff)
    );

    localparam int SrcPc = 0, SrcMdr = 1, SrcZhi = 2, SrcZlo = 3, SrcHi = 4, SrcLo = 5, SrcC = 6;
    localparam int DPc = 0, DMar = 1, DMdr = 2, DY = 3, DHi = 4, DLo = 5, DOut = 6;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string name, input logic [3:0] op, input logic [31:0] a, b,
                           input logic [31:0] lo, hi);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.lo = lo; v.hi = hi;
        vecs.push_back(v);
    endtask

    task automatic clear_ctrl();
        {PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout, InPortout, Rout, BAout} = '0;
        {PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Rin, CONin, OutPortin} = '0;
        {Gra, Grb, Grc, Read, Write, IncPC} = '0;
        alu_op = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_ctrl();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic peek(input int src, output logic [31:0] v);
        @(negedge clk);
        case (src)
            SrcPc:   PCout = 1'b1;
            SrcMdr:  MDRout = 1'b1;
            SrcZhi:  Zhighout = 1'b1;
            SrcZlo:  Zlowout = 1'b1;
            SrcHi:   HIout = 1'b1;
            SrcLo:   LOout = 1'b1;
            default: Cout = 1'b1;
        endcase
        #1 v = bus;
        clear_ctrl();
    endtask

    task automatic put(input logic [31:0] v, input int dst);
        @(negedge clk);
        in_port = v;
        InPortout = 1'b1;
        case (dst)
            DPc:     PCin = 1'b1;
            DMar:    MARin = 1'b1;
            DMdr:    MDRin = 1'b1;
            DY:      Yin = 1'b1;
            DHi:     HIin = 1'b1;
            DLo:     LOin = 1'b1;
            default: OutPortin = 1'b1;
        endcase
        tick();
    endtask

    task automatic set_ir(input logic [31:0] v);
        @(negedge clk);
        in_port = v; InPortout = 1'b1; IRin = 1'b1;
        tick();
    endtask

    task automatic set_reg(input logic [3:0] i, input logic [31:0] v);
        set_ir({5'd0, i, 23'd0});
        @(negedge clk);
        in_port = v; InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        tick();
    endtask

    task automatic read_reg(input logic [3:0] i, input logic use_ba, output logic [31:0] v);
        set_ir({5'd0, i, 23'd0});
        @(negedge clk);
        Gra = 1'b1;
        if (use_ba) BAout = 1'b1; else Rout = 1'b1;
        #1 v = bus;
        clear_ctrl();
    endtask

    task automatic mem_write(input logic [31:0] addr, input logic [31:0] data);
        put(addr, DMar);
        put(data, DMdr);
        @(negedge clk);
        Write = 1'b1;
        tick();
    endtask

    task automatic mem_read(input logic [31:0] addr, output logic [31:0] v);
        put(addr, DMar);
        @(negedge clk);
        Read = 1'b1; MDRin = 1'b1;
        tick();
        peek(SrcMdr, v);
    endtask

    task automatic run_alu(input logic [3:0] op, input logic [31:0] a, b,
                           output logic [31:0] lo, hi);
        put(a, DY);
        @(negedge clk);
        in_port = b; InPortout = 1'b1; alu_op = op; Zin = 1'b1;
        tick();
        peek(SrcZlo, lo);
        peek(SrcZhi, hi);
    endtask

    task automatic con_test(input logic [1:0] c2, input logic [31:0] val, input logic exp);
        set_ir({11'd0, c2, 19'd0});
        @(negedge clk);
        in_port = val; InPortout = 1'b1; CONin = 1'b1;
        tick();
        check($sformatf("con c2=%0d bus=%08h", c2, val), {31'd0, con_ff}, {31'd0, exp});
    endtask

    // Reference ALU written with plain integer arithmetic
    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b);
        int          sa  = a;
        int          sb  = b;
        int          amt = int'(b[4:0]);
        logic [63:0] dbl = {a, a};
        logic [63:0] tmp;
        longint      p;
        case (op)
            4'd0:  return {32'd0, a + b};
            4'd1:  return {32'd0, a - b};
            4'd2:  return {32'd0, a & b};
            4'd3:  return {32'd0, a | b};
            4'd4:  return {32'd0, a >> amt};
            4'd5:  return {32'd0, 32'(sa >>> amt)};
            4'd6:  return {32'd0, a << amt};
            4'd7:  begin tmp = dbl >> amt; return {32'd0, tmp[31:0]}; end
            4'd8:  begin tmp = dbl << amt; return {32'd0, tmp[63:32]}; end
            4'd9:  begin p = longint'(sa) * longint'(sb); return 64'(p); end
            4'd10: begin
                if (sb == 0) return 64'd0;
                return {32'(sa % sb), 32'(sa / sb)};
            end
            4'd11: return {32'd0, 32'(-sb)};
            4'd12: return {32'd0, ~b};
            default: return 64'd0;
        endcase
    endfunction

    initial begin
        logic [31:0] v, lo, hi, a, b;
        logic [3:0]  op;
        logic [63:0] exp;

        clear_ctrl();
        in_port = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        peek(SrcPc, v);  check("reset pc", v, 32'd0);
        peek(SrcZlo, v); check("reset zlo", v, 32'd0);
        peek(SrcZhi, v); check("reset zhi", v, 32'd0);
        peek(SrcC, v);   check("reset ir c", v, 32'd0);
        check("reset out_port", out_port, 32'd0);
        check("reset con_ff", {31'd0, con_ff}, 32'd0);
        #1 check("idle bus", bus, 32'd0);

        // Fetch: PC=7, mem[7]=0x10800023
        mem_write(32'd7, 32'h1080_0023);
        put(32'd7, DPc);
        @(negedge clk); PCout = 1; MARin = 1; IncPC = 1; Zin = 1; tick();
        peek(SrcZlo, v); check("fetch T0 z", v, 32'd8);
        @(negedge clk); Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; tick();
        peek(SrcPc, v);  check("fetch T1 pc", v, 32'd8);
        peek(SrcMdr, v); check("fetch T1 mdr", v, 32'h1080_0023);
        @(negedge clk); MDRout = 1; IRin = 1; tick();
        peek(SrcC, v);   check("fetch T2 ir c", v, 32'd35);

        @(negedge clk); Cout = 1; Gra = 1; Rin = 1; tick();
        @(negedge clk); Gra = 1; Rout = 1; #1 v = bus; clear_ctrl();
        check("r1 from c", v, 32'd35);
        @(negedge clk); Gra = 1; Rout = 1; PCin = 1; tick();
        peek(SrcPc, v);  check("pc from r1", v, 32'd35);

        // Negative C sign-extends
        set_ir(32'h0004_0000);
        peek(SrcC, v);   check("c sext", v, 32'hFFFC_0000);

        // Register-file ALU path: R3 = R1 op R2
        set_reg(4'd2, 32'd7);
        put(32'h0000_FFFF, DHi);
        for (int k = 0; k < 3; k++) begin
            op = (k == 0) ? 4'd0 : (k == 1) ? 4'd1 : 4'd9;
            set_ir({5'd0, 4'd3, 4'd1, 4'd2, 15'd0});
            @(negedge clk); Grb = 1; Rout = 1; Yin = 1; tick();
            @(negedge clk); Grc = 1; Rout = 1; alu_op = op; Zin = 1; tick();
            @(negedge clk); Zlowout = 1; Gra = 1; Rin = 1; tick();
            @(negedge clk); Gra = 1; BAout = 1; #1 v = bus; clear_ctrl();
            check($sformatf("r3 op%0d", op), v, (k == 0) ? 32'd42 : (k == 1) ? 32'd28 : 32'd245);
        end
        @(negedge clk); Zlowout = 1; LOin = 1; tick();
        @(negedge clk); Zhighout = 1; HIin = 1; tick();
        peek(SrcLo, v); check("mul lo", v, 32'd245);
        peek(SrcHi, v); check("mul hi", v, 32'd0);

        // BAout yields 0 for R0, Rout does not
        set_reg(4'd0, 32'h55);
        read_reg(4'd0, 1'b0, v); check("r0 rout", v, 32'h55);
        read_reg(4'd0, 1'b1, v); check("r0 baout", v, 32'd0);

        // ALU vector table
        add_vec("add",       4'd0,  32'd35,        32'd7,         32'd42,        32'd0);
        add_vec("sub neg",   4'd1,  32'd7,         32'd35,        32'hFFFF_FFE4, 32'd0);
        add_vec("and",       4'd2,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 32'd0);
        add_vec("or",        4'd3,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 32'd0);
        add_vec("shr",       4'd4,  32'h8000_0000, 32'd4,         32'h0800_0000, 32'd0);
        add_vec("shra",      4'd5,  32'h8000_0000, 32'd4,         32'hF800_0000, 32'd0);
        add_vec("shl",       4'd6,  32'd1,         32'd31,        32'h8000_0000, 32'd0);
        add_vec("ror",       4'd7,  32'd1,         32'd1,         32'h8000_0000, 32'd0);
        add_vec("ror amt32", 4'd7,  32'h1234_5678, 32'd32,        32'h1234_5678, 32'd0);
        add_vec("rol",       4'd8,  32'h8000_0001, 32'd4,         32'h0000_0018, 32'd0);
        add_vec("mul neg",   4'd9,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFA, 32'hFFFF_FFFF);
        add_vec("mul carry", 4'd9,  32'h0001_0000, 32'h0001_0000, 32'd0,         32'd1);
        add_vec("div",       4'd10, 32'd17,        32'd5,         32'd3,         32'd2);
        add_vec("div neg",   4'd10, 32'hFFFF_FFEF, 32'd5,         32'hFFFF_FFFD, 32'hFFFF_FFFE);
        add_vec("div zero",  4'd10, 32'd5,         32'd0,         32'd0,         32'd0);
        add_vec("neg",       4'd11, 32'd9,         32'd1,         32'hFFFF_FFFF, 32'd0);
        add_vec("not",       4'd12, 32'd9,         32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'd0);
        add_vec("op14",      4'd14, 32'd5,         32'd6,         32'd0,         32'd0);
        foreach (vecs[i]) begin
            run_alu(vecs[i].op, vecs[i].a, vecs[i].b, lo, hi);
            check({vecs[i].name, " lo"}, lo, vecs[i].lo);
            check({vecs[i].name, " hi"}, hi, vecs[i].hi);
        end

        // Randomized ALU against the reference model
        for (int i = 0; i < 120; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 40);
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            exp = ref_alu(op, a, b);
            run_alu(op, a, b, lo, hi);
            check($sformatf("rand op%0d a=%08h b=%08h lo", op, a, b), lo, exp[31:0]);
            check($sformatf("rand op%0d a=%08h b=%08h hi", op, a, b), hi, exp[63:32]);
        end

        // IncPC overrides alu_op; a Z source feeding Z sees the old value
        @(negedge clk); in_port = 32'h99; InPortout = 1; IncPC = 1; alu_op = 4'd1; Zin = 1; tick();
        peek(SrcZlo, v); check("incpc", v, 32'h9A);
        @(negedge clk); Zlowout = 1; IncPC = 1; Zin = 1; tick();
        peek(SrcZlo, v); check("z old value", v, 32'h9B);

        // Bus priority
        put(32'h1234, DPc);
        put(32'hABCD, DMdr);
        @(negedge clk); PCout = 1; MDRout = 1; #1 check("prio pc>mdr", bus, 32'h1234);
        PCout = 0; Zlowout = 1; #1 check("prio mdr>z", bus, 32'hABCD);
        clear_ctrl(); in_port = 32'h77; InPortout = 1; Rout = 1;
        #1 check("prio inport>r", bus, 32'h77);
        clear_ctrl();

        put(32'hCAFE_F00D, DOut);
        check("out_port", out_port, 32'hCAFE_F00D);

        // Branch condition
        con_test(2'b00, 32'd0, 1'b1);
        con_test(2'b11, 32'h8000_0000, 1'b1);
        con_test(2'b01, 32'd0, 1'b0);
        con_test(2'b10, 32'h7FFF_FFFF, 1'b1);
        con_test(2'b10, 32'h8000_0000, 1'b0);
        con_test(2'b00, 32'd5, 1'b0);

        // Memory write then read back
        mem_write(32'd20, 32'hDEAD_BEEF);
        mem_read(32'd20, v); check("mem readback", v, 32'hDEAD_BEEF);

        // Reset mid-sequence overrides enables and a pending Write
        con_test(2'b00, 32'd0, 1'b1);
        put(32'd20, DMar);
        put(32'h1111_1111, DMdr);
        @(negedge clk);
        reset = 1; Write = 1; in_port = 32'h77; InPortout = 1; PCin = 1; Zin = 1; IncPC = 1;
        tick();
        reset = 0;
        check("rst con_ff", {31'd0, con_ff}, 32'd0);
        check("rst out_port", out_port, 32'd0);
        peek(SrcPc, v);  check("rst pc", v, 32'd0);
        peek(SrcZlo, v); check("rst z", v, 32'd0);
        peek(SrcC, v);   check("rst ir", v, 32'd0);
        read_reg(4'd1, 1'b0, v); check("rst r1", v, 32'd0);
        mem_read(32'd20, v); check("rst ram kept", v, 32'hDEAD_BEEF);
        mem_read(32'd7, v);  check("rst ram kept 7", v, 32'h1080_0023);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
